// File: rtl/trigger_driver_pkg.sv
// Shared definitions for the armed-line trigger protocol (driver and detector benches).
package trigger_driver_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } trig_state_e;

endpackage

// File: rtl/trigger_driver.sv
// Transmit side of the armed-line trigger protocol: programmable delay, then a
// programmable-width high pulse on dout. All outputs are registered.
module trigger_driver
    import trigger_driver_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    output logic             busy,
    output logic             arm,
    output logic             dout,
    output logic             done
);

    trig_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] width_q, width_n;
    logic             done_n;
    logic             last;

    assign last = (cnt == CNT_W'(1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        width_n = width_q;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    width_n = width;
                    if (delay != '0) begin
                        state_n = ST_DELAY;
                        cnt_n   = delay;
                    end else if (width != '0) begin
                        state_n = ST_PULSE;
                        cnt_n   = width;
                    end else begin
                        done_n  = 1'b1;    // empty sequence completes at once
                    end
                end
            end
            ST_DELAY: begin
                if (last) begin
                    if (width_q != '0) begin
                        state_n = ST_PULSE;
                        cnt_n   = width_q;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (last) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        // abort only matters mid-sequence; in IDLE it merely blocks the accept above
        if (abort && state != ST_IDLE) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            width_q <= '0;
            busy    <= 1'b0;
            arm     <= 1'b0;
            dout    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            width_q <= width_n;
            busy    <= (state_n != ST_IDLE);
            dout    <= (state_n == ST_PULSE);
            arm     <= (state_n == ST_PULSE) && (state != ST_PULSE);
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_trigger_driver.sv
// Directed bench for trigger_driver; outputs checked 1 time unit after each rising edge.
module tb_trigger_driver;
    import trigger_driver_pkg::*;

    localparam int CNT_W = CNT_W_DEF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] delay = '0;
    logic [CNT_W-1:0] width = '0;
    logic             busy, arm, dout, done;

    int nvec = 0;
    int nerr = 0;

    trigger_driver #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .abort(abort),
        .delay(delay),
        .width(width),
        .busy (busy),
        .arm  (arm),
        .dout (dout),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp packs {busy, arm, dout, done}
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] got;
        got = {busy, arm, dout, done};
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: {busy,arm,dout,done} got %b exp %b", tag, got, exp);
        end
    endtask

    // Cycle k after the accepting edge (k=0 is the cycle right after it):
    // busy for k<d+w, dout for d<=k<d+w, arm at k==d, done at k==d+w.
    function automatic logic [3:0] model(input int d, input int w, input int k);
        logic b, a, o, n;
        b = (k < d + w);
        a = (w > 0) && (k == d);
        o = (w > 0) && (k >= d) && (k < d + w);
        n = (k == d + w);
        return {b, a, o, n};
    endfunction

    task automatic run_seq(input int d, input int w, input string tag);
        delay = CNT_W'(d);
        width = CNT_W'(w);
        start = 1'b1;
        step();
        start = 1'b0;
        // scrambling operands after accept must not disturb the running sequence
        delay = CNT_W'($urandom);
        width = CNT_W'($urandom);
        for (int k = 0; k <= d + w + 1; k++) begin
            if (k > 0) step();
            chk(tag, model(d, w, k));
        end
    endtask

    initial begin
        // reset held 3 cycles, then idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle", 4'b0000);
        end

        run_seq(3, 5, "d3w5");
        run_seq(0, 1, "d0w1");
        run_seq(2, 0, "d2w0");
        run_seq(0, 0, "d0w0");
        run_seq(7, 3, "d7w3");

        // start held high throughout a d=1/w=4 run: one pulse, re-accept after done
        delay = CNT_W'(1);
        width = CNT_W'(4);
        start = 1'b1;
        step();
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            chk("start_held", model(1, 4, k));
        end
        step();
        start = 1'b0;
        chk("reaccept", model(1, 4, 0));
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("reaccept_run", model(1, 4, k));
        end

        // abort in the second pulse cycle: line drops, no done
        delay = '0;
        width = CNT_W'(8);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_p1", 4'b1110);
        step();
        chk("abort_p2", 4'b1010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_drop", 4'b0000);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("abort_quiet", 4'b0000);
        end

        // same with reset
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_p1", 4'b1110);
        step();
        chk("rst_p2", 4'b1010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_drop", 4'b0000);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rst_quiet", 4'b0000);
        end

        // abort in IDLE blocks a simultaneous start
        delay = CNT_W'(1);
        width = CNT_W'(1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_idle", 4'b0000);
        step();
        chk("abort_idle2", 4'b0000);

        // abort during the delay phase
        delay = CNT_W'(4);
        width = CNT_W'(2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_dly0", 4'b1000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_dly1", 4'b0000);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_dly_quiet", 4'b0000);
        end

        // back-to-back runs still work after the aborts
        run_seq(1, 2, "d1w2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
